// File: rtl/openofdm_rx_ctrl_pkg.sv
// Shared types for the OpenOFDM receive controller: FSM states, result codes
// and the layout of the per-packet status word.
package openofdm_rx_ctrl_pkg;

   localparam int unsigned STATUS_W  = 32;
   localparam int unsigned PKT_LEN_W = 16;
   localparam int unsigned CODE_W    = 3;

   localparam int unsigned STAT_LEN_LSB      = 0;
   localparam int unsigned STAT_CODE_LSB     = 16;
   localparam int unsigned STAT_MISMATCH_BIT = 19;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SIG  = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_RST_CORE  = 3'd3,
      ST_REPORT    = 3'd4
   } state_e;

   typedef enum logic [CODE_W-1:0] {
      RES_OK           = 3'd0,
      RES_FCS_ERR      = 3'd1,
      RES_SIG_BAD      = 3'd2,
      RES_HT_UNSUP     = 3'd3,
      RES_SIG_TIMEOUT  = 3'd4,
      RES_DATA_TIMEOUT = 3'd5
   } res_code_e;

   // Status word: header length, result code, and a flag for byte count != header length.
   function automatic logic [STATUS_W-1:0] pack_status(input logic [PKT_LEN_W-1:0] len,
                                                       input res_code_e code,
                                                       input logic [PKT_LEN_W-1:0] nbytes);
      logic [STATUS_W-1:0] w;
      w = '0;
      w[STAT_LEN_LSB +: PKT_LEN_W] = len;
      w[STAT_CODE_LSB +: CODE_W]   = code;
      w[STAT_MISMATCH_BIT]         = (nbytes != len);
      return w;
   endfunction

endpackage

// File: rtl/openofdm_rx_ctrl_if.sv
// Per-packet status record handshake between the receive controller and its consumer.
interface openofdm_rx_ctrl_if;
   import openofdm_rx_ctrl_pkg::*;

   logic                status_valid;
   logic                status_ready;
   logic [STATUS_W-1:0] status_data;

   modport master (output status_valid, output status_data, input status_ready);
   modport slave  (input status_valid, input status_data, output status_ready);

endinterface

// File: rtl/openofdm_rx_ctrl_timer.sv
// Per-state cycle counter; clear_i marks the first cycle of a state and takes effect immediately.
module openofdm_rx_ctrl_timer #(
   parameter int unsigned TIMER_WIDTH = 20
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   enable_i,
   input  logic [TIMER_WIDTH-1:0] threshold_i,
   output logic                   expired_c_o
);

   logic [TIMER_WIDTH-1:0] count_q;
   logic [TIMER_WIDTH-1:0] count_d;

   always_comb begin
      count_d     = clear_i ? '0 : count_q;
      expired_c_o = (threshold_i != '0) && (count_d == threshold_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_d + TIMER_WIDTH'(1);
      end else begin
         count_q <= '0;
      end
   end

endmodule

// File: rtl/openofdm_rx_ctrl.sv
// OpenOFDM receive controller: packet acquisition, timeouts, core reset and status reporting.
// Define OPENOFDM_RX_CTRL_STAT_EN to add the per-result packet counters.
module openofdm_rx_ctrl
   import openofdm_rx_ctrl_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH   = 20,
   parameter int unsigned RST_PULSE_LEN = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   short_preamble_detected,
   input  logic                   pkt_header_valid_strobe,
   input  logic                   pkt_header_valid,
   input  logic                   ht_unsupport,
   input  logic [PKT_LEN_W-1:0]   pkt_len,
   input  logic                   byte_out_strobe,
   input  logic                   fcs_out_strobe,
   input  logic                   fcs_ok,
   input  logic [TIMER_WIDTH-1:0] sig_timeout_th,
   input  logic [TIMER_WIDTH-1:0] data_timeout_th,
   output logic                   core_rst,
   output logic                   busy,
   openofdm_rx_ctrl_if.master     status
`ifdef OPENOFDM_RX_CTRL_STAT_EN
   ,
   output logic [15:0]            cnt_ok,
   output logic [15:0]            cnt_fcs_err,
   output logic [15:0]            cnt_abort
`endif
);

   localparam int unsigned PULSE_W = 4;

   state_e                 state_q;
   res_code_e              code_q;
   logic [PKT_LEN_W-1:0]   len_q;
   logic [PKT_LEN_W-1:0]   bytes_q;
   logic [PULSE_W-1:0]     pulse_q;
   logic                   entry_q;

   logic                   tmr_en_c;
   logic                   tmr_exp_c;
   logic [TIMER_WIDTH-1:0] tmr_th_c;
   logic [PKT_LEN_W-1:0]   bytes_inc_c;

   always_comb begin
      tmr_en_c    = (state_q == ST_WAIT_SIG) || (state_q == ST_WAIT_DATA);
      tmr_th_c    = (state_q == ST_WAIT_DATA) ? data_timeout_th : sig_timeout_th;
      bytes_inc_c = (byte_out_strobe && (bytes_q != 16'hFFFF)) ? bytes_q + 16'd1 : bytes_q;
   end

   openofdm_rx_ctrl_timer #(.TIMER_WIDTH(TIMER_WIDTH)) timer_u (
      .clk_i       (clock),
      .rst_i       (reset),
      .clear_i     (entry_q),
      .enable_i    (tmr_en_c),
      .threshold_i (tmr_th_c),
      .expired_c_o (tmr_exp_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q             <= ST_IDLE;
         code_q              <= RES_OK;
         len_q               <= '0;
         bytes_q             <= '0;
         pulse_q             <= '0;
         entry_q             <= 1'b0;
         core_rst            <= 1'b0;
         busy                <= 1'b0;
         status.status_valid <= 1'b0;
         status.status_data  <= '0;
`ifdef OPENOFDM_RX_CTRL_STAT_EN
         cnt_ok              <= '0;
         cnt_fcs_err         <= '0;
         cnt_abort           <= '0;
`endif
      end else begin
         entry_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable && short_preamble_detected) begin
                  state_q <= ST_WAIT_SIG;
                  entry_q <= 1'b1;
                  busy    <= 1'b1;
                  len_q   <= '0;
                  bytes_q <= '0;
               end
            end
            ST_WAIT_SIG: begin
               if (pkt_header_valid_strobe) begin
                  entry_q <= 1'b1;
                  if (!pkt_header_valid || ht_unsupport) begin
                     state_q  <= ST_RST_CORE;
                     code_q   <= !pkt_header_valid ? RES_SIG_BAD : RES_HT_UNSUP;
                     core_rst <= 1'b1;
                     pulse_q  <= PULSE_W'(1);
                  end else begin
                     state_q <= ST_WAIT_DATA;
                     len_q   <= pkt_len;
                     bytes_q <= '0;
                  end
               end else if (tmr_exp_c) begin
                  state_q  <= ST_RST_CORE;
                  entry_q  <= 1'b1;
                  code_q   <= RES_SIG_TIMEOUT;
                  core_rst <= 1'b1;
                  pulse_q  <= PULSE_W'(1);
               end
            end
            ST_WAIT_DATA: begin
               bytes_q <= bytes_inc_c;
               if (fcs_out_strobe) begin
                  state_q             <= ST_REPORT;
                  entry_q             <= 1'b1;
                  code_q              <= fcs_ok ? RES_OK : RES_FCS_ERR;
                  status.status_valid <= 1'b1;
                  status.status_data  <= pack_status(len_q, fcs_ok ? RES_OK : RES_FCS_ERR, bytes_inc_c);
               end else if (tmr_exp_c) begin
                  state_q  <= ST_RST_CORE;
                  entry_q  <= 1'b1;
                  code_q   <= RES_DATA_TIMEOUT;
                  core_rst <= 1'b1;
                  pulse_q  <= PULSE_W'(1);
               end
            end
            ST_RST_CORE: begin
               if (pulse_q == PULSE_W'(RST_PULSE_LEN)) begin
                  state_q             <= ST_REPORT;
                  entry_q             <= 1'b1;
                  core_rst            <= 1'b0;
                  status.status_valid <= 1'b1;
                  status.status_data  <= pack_status(len_q, code_q, bytes_q);
               end else begin
                  pulse_q <= pulse_q + PULSE_W'(1);
               end
            end
            ST_REPORT: begin
               // Datapath inputs are ignored here; only the status handshake matters.
               if (status.status_ready) begin
                  state_q             <= ST_IDLE;
                  entry_q             <= 1'b1;
                  busy                <= 1'b0;
                  status.status_valid <= 1'b0;
`ifdef OPENOFDM_RX_CTRL_STAT_EN
                  if (code_q == RES_OK) begin
                     cnt_ok <= cnt_ok + 16'd1;
                  end else if (code_q == RES_FCS_ERR) begin
                     cnt_fcs_err <= cnt_fcs_err + 16'd1;
                  end else begin
                     cnt_abort <= cnt_abort + 16'd1;
                  end
`endif
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/openofdm_rx_ctrl.md
OPENOFDM_RX_CTRL -- requirements
Module: openofdm_rx_ctrl

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 20, width of timeout counters and thresholds.
REQ-002 SHALL have parameter RST_PULSE_LEN, default 4, core_rst pulse length in cycles (1..15).
REQ-003 SHALL have port clock  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  permits new packet acquisition.
REQ-006 SHALL have port short_preamble_detected  in  1  preamble detect pulse from dot11.
REQ-007 SHALL have ports pkt_header_valid_strobe / pkt_header_valid / ht_unsupport  in  1 each  SIGNAL decode result.
REQ-008 SHALL have port pkt_len  in  16  header length in bytes, sampled on header strobe.
REQ-009 SHALL have port byte_out_strobe  in  1  one decoded byte.
REQ-010 SHALL have ports fcs_out_strobe / fcs_ok  in  1 each  end-of-packet CRC result.
REQ-011 SHALL have ports sig_timeout_th / data_timeout_th  in  TIMER_WIDTH each  cycle limits; 0 disables that timeout.
REQ-012 SHALL have port core_rst  out  1  reset request to dot11 core.
REQ-013 SHALL have port busy  out  1  high in any state except IDLE.
REQ-014 SHALL have ports status_valid  out  1 / status_ready  in  1 / status_data  out  32  per-packet status record.

Function
REQ-015 SHALL implement states IDLE, WAIT_SIG, WAIT_DATA, RST_CORE, REPORT.
REQ-016 IDLE -> WAIT_SIG on short_preamble_detected when enable=1; ignored when enable=0.
REQ-017 WAIT_SIG: header strobe with valid=1, ht_unsupport=0 -> WAIT_DATA (latch pkt_len); valid=0 -> RST_CORE code SIG_BAD; ht_unsupport=1 -> RST_CORE code HT_UNSUP.
REQ-018 WAIT_DATA: fcs_out_strobe -> REPORT, code OK if fcs_ok=1 else FCS_ERR; no core reset.
REQ-019 Timer clears on every state entry, increments per cycle in WAIT_SIG/WAIT_DATA; timer == nonzero threshold -> RST_CORE with SIG_TIMEOUT/DATA_TIMEOUT.
REQ-020 Event strobe and timeout in same cycle: strobe wins.
REQ-021 RST_CORE: core_rst high exactly RST_PULSE_LEN cycles, registered, then REPORT.
REQ-022 REPORT: status_valid high, status_data stable until status_valid & status_ready; transfer cycle -> IDLE; all datapath inputs ignored in REPORT.
REQ-023 Byte counter clears on WAIT_DATA entry, increments on byte_out_strobe, saturates at 16'hFFFF.
REQ-024 status_data: [15:0] latched pkt_len (0 if no header), [18:16] code (0 OK,1 FCS_ERR,2 SIG_BAD,3 HT_UNSUP,4 SIG_TIMEOUT,5 DATA_TIMEOUT), [19] byte count != pkt_len at report, [31:20] zero.
REQ-025 enable deassert outside IDLE SHALL NOT abort the current packet.
REQ-026 All outputs SHALL be registered; state transitions take effect the cycle after the triggering input.

Reset
REQ-027 reset SHALL force IDLE, core_rst=0, busy=0, status_valid=0, status_data=0, timer, byte counter and statistics counters to 0, from any state including mid-RST_CORE or REPORT.

Configuration
REQ-028 Macro OPENOFDM_RX_CTRL_STAT_EN defined: adds outputs cnt_ok, cnt_fcs_err, cnt_abort (16 bits each, out), incremented on REPORT handshake by code (abort = codes 2..5), wrapping at 16'hFFFF.
REQ-029 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold the state encoding and status result code constants and status_data field positions.
REQ-031 One sub-module openofdm_rx_ctrl_timer (clear/enable/threshold/expired) SHALL be natural; all else inline.

Verification
REQ-032 Preamble, header valid pkt_len=100, 100 byte strobes, fcs_ok=1 -> status_data=0x00000064, no core_rst.
REQ-033 Preamble, header valid pkt_len=50, 49 bytes, fcs_ok=0 -> status_data=0x00090032.
REQ-034 sig_timeout_th=200, preamble, no header -> core_rst high 4 cycles starting cycle ~201, status code 4, pkt_len 0.
REQ-035 Header strobe on same cycle timer hits threshold -> WAIT_DATA, no timeout.
REQ-036 status_ready held low 10 cycles in REPORT with preamble pulses -> status_data stable, no new packet; after handshake -> IDLE.
REQ-037 reset asserted during RST_CORE -> core_rst=0 next cycle, IDLE, status_valid=0; with STAT_EN counters read 0.
